// File: rtl/zx_video_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zx_video_pkg : shared constants and slot encodings for zx_vmem_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package zx_video_pkg;

   localparam int          ADDR_W       = 13;
   localparam int          FIFO_DEPTH   = 4;
   localparam logic [12:0] ATTR_BASE    = 13'h1800;
   localparam int          SCREEN_BYTES = 6912;

   typedef enum logic [1:0] {
      SLOT_VID0 = 2'd0,
      SLOT_CPU0 = 2'd1,
      SLOT_VID1 = 2'd2,
      SLOT_CPU1 = 2'd3
   } slot_e;

   function automatic logic is_cpu_slot(input slot_e s);
      return s[0];
   endfunction

   function automatic logic is_attr_addr(input logic [12:0] a);
      return (a >= ATTR_BASE) && (a < 13'(SCREEN_BYTES));
   endfunction

endpackage
`default_nettype wire

// File: rtl/zx_vmem_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zx_vmem_fifo : CPU write buffer holding {address, data} entries
// Rev 1.0
// ----------------------------------------------------------------------------
module zx_vmem_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 21
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   import zx_video_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Guards keep the pointers consistent even if a caller misbehaves.
   assign push = push_i && !full_o;
   assign pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/zx_vmem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zx_vmem_ctrl : video RAM arbiter interleaving display reads and buffered CPU access
// Rev 1.0
// ----------------------------------------------------------------------------
module zx_vmem_ctrl #(
   parameter int ADDR_W     = zx_video_pkg::ADDR_W,
   parameter int FIFO_DEPTH = zx_video_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] video_addr,
   output logic [7:0]        video_data,
   output logic [2:0]        border,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ready,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              io_we,
   input  logic [2:0]        io_data
);
   import zx_video_pkg::*;

   localparam int FW    = ADDR_W + 8;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   slot_e             slot_q, slot_d;
   logic              rd_pending_q, rd_pending_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]        video_data_q, video_data_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [2:0]        border_q, border_d;

   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [FW-1:0]     fifo_din, fifo_dout;
   logic [CNT_W-1:0]  fifo_count_unused;

   logic [7:0]        mem [2**ADDR_W];
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata, ram_rdata;
   logic              accept, cpu_slot, do_read;

   assign cpu_ready = !fifo_full && !rd_pending_q;
   assign accept    = cpu_req && cpu_ready;
   assign fifo_push = accept && cpu_we;
   assign fifo_din  = {cpu_addr, cpu_wdata};
   assign cpu_slot  = is_cpu_slot(slot_q);
   // A read only proceeds once every earlier write has reached the RAM.
   assign fifo_pop  = cpu_slot && !fifo_empty;
   assign do_read   = cpu_slot && fifo_empty && rd_pending_q;

   zx_vmem_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (fifo_din),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_unused)
   );

   always_comb begin
      ram_addr  = video_addr;
      ram_we    = 1'b0;
      ram_wdata = fifo_dout[7:0];
      if (do_read) begin
         ram_addr = rd_addr_q;
      end else if (fifo_pop) begin
         ram_addr = fifo_dout[FW-1:8];
         ram_we   = 1'b1;
      end
   end

   assign ram_rdata = mem[ram_addr];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   always_comb begin
      slot_d       = slot_e'(slot_q + 2'd1);
      video_data_d = cpu_slot ? video_data_q : ram_rdata;
      rd_pending_d = rd_pending_q;
      rd_addr_d    = rd_addr_q;
      cpu_rdata_d  = do_read ? ram_rdata : cpu_rdata_q;
      cpu_rvalid_d = do_read;
      border_d     = io_we ? io_data : border_q;
      if (do_read) begin
         rd_pending_d = 1'b0;
      end else if (accept && !cpu_we) begin
         rd_pending_d = 1'b1;
         rd_addr_d    = cpu_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q       <= SLOT_VID0;
         rd_pending_q <= 1'b0;
         rd_addr_q    <= '0;
         video_data_q <= 8'h00;
         cpu_rdata_q  <= 8'h00;
         cpu_rvalid_q <= 1'b0;
         border_q     <= 3'b000;
      end else begin
         slot_q       <= slot_d;
         rd_pending_q <= rd_pending_d;
         rd_addr_q    <= rd_addr_d;
         video_data_q <= video_data_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         border_q     <= border_d;
      end
   end

   assign video_data = video_data_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign border     = border_q;

endmodule
`default_nettype wire

// File: tb/tb_zx_vmem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_zx_vmem_ctrl : randomized scoreboard bench for zx_vmem_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_zx_vmem_ctrl;
   import zx_video_pkg::*;

   localparam int AW    = 13;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] video_addr = '0;
   logic [7:0]    video_data;
   logic [2:0]    border;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          cpu_ready;
   logic [7:0]    cpu_rdata;
   logic          cpu_rvalid;
   logic          io_we = 1'b0;
   logic [2:0]    io_data = '0;

   always #5 clk = ~clk;

   zx_vmem_ctrl #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .video_addr (video_addr),
      .video_data (video_data),
      .border     (border),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .io_we      (io_we),
      .io_data    (io_data)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   // Reference model: pending writes, RAM image, read scoreboard.
   wr_t           wq[$];
   logic [7:0]    refmem [int];
   logic [7:0]    exp_q[$];
   bit            m_rd_pend = 0;
   logic [AW-1:0] m_rd_addr = '0;
   bit            m_rvalid = 0;
   logic [7:0]    m_rdata = '0;
   bit            m_rdata_known = 1;
   logic [7:0]    m_vid = '0;
   bit            m_vid_known = 1;
   logic [2:0]    m_border = '0;
   int            m_cyc = 0;

   logic [AW-1:0] pool [12] = '{13'h0000, 13'h0001, 13'h0100, 13'h1234,
                                13'h17FF, 13'h1800, 13'h1801, 13'h1802,
                                13'h1803, 13'h1AFF, 13'h1B00, 13'h1FFF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      bit  ready;
      wr_t e;
      if (rst) begin
         wq.delete();
         exp_q.delete();
         m_rd_pend     = 0;
         m_rvalid      = 0;
         m_rdata       = 8'h00;
         m_rdata_known = 1;
         m_vid         = 8'h00;
         m_vid_known   = 1;
         m_border      = 3'b000;
         m_cyc         = 0;
      end else begin
         ready    = (wq.size() < DEPTH) && !m_rd_pend;
         m_rvalid = 0;
         if (m_cyc % 2 == 0) begin
            if (refmem.exists(int'(video_addr))) begin
               m_vid       = refmem[int'(video_addr)];
               m_vid_known = 1;
            end else begin
               m_vid_known = 0;
            end
         end else if (wq.size() != 0) begin
            e = wq.pop_front();
            refmem[int'(e.a)] = e.d;
         end else if (m_rd_pend) begin
            m_rd_pend = 0;
            m_rvalid  = 1;
            if (refmem.exists(int'(m_rd_addr))) begin
               m_rdata       = refmem[int'(m_rd_addr)];
               m_rdata_known = 1;
               exp_q.push_back(m_rdata);
            end else begin
               m_rdata_known = 0;
               exp_q.push_back(8'hxx);
            end
         end
         if (cpu_req && ready) begin
            if (cpu_we) begin
               e.a = cpu_addr;
               e.d = cpu_wdata;
               wq.push_back(e);
            end else begin
               m_rd_pend = 1;
               m_rd_addr = cpu_addr;
            end
         end
         if (io_we) m_border = io_data;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      chk("cpu_ready", 32'(cpu_ready), 32'((wq.size() < DEPTH) && !m_rd_pend));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
      chk("border", 32'(border), 32'(m_border));
      if (m_vid_known) chk("video_data", 32'(video_data), 32'(m_vid));
      if (m_rdata_known) chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(m_rdata));
      if (cpu_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: actual=1 expected=0 (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            if (!$isunknown(e)) chk("read_data", 32'(cpu_rdata), 32'(e));
         end
      end
   end

   task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d);
      int n = 0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      @(negedge clk);
      while (!cpu_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual=ready0 expected=ready1 addr=%0h", a);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic wait_read(input string name, input logic [7:0] exp);
      int n = 0;
      while (!cpu_rvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (cpu_rvalid) chk(name, 32'(cpu_rdata), 32'(exp));
      else begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: actual=no_rvalid expected=rvalid", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_write_not(input logic [AW-1:0] avoid);
      logic [AW-1:0] a;
      a = pool[$urandom_range(0, 11)];
      while (a == avoid) a = pool[$urandom_range(0, 11)];
      cpu_op(1'b1, a, 8'($urandom));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]    old_v [6];
      logic [7:0]    new_v [6];
      logic [AW-1:0] rt [6] = '{13'h0100, 13'h1234, 13'h17FF, 13'h1B00, 13'h1FFF, 13'h0001};

      idle(3);
      rst = 1'b0;

      // Write followed immediately by a read of the same byte.
      cpu_op(1'b1, 13'h0000, 8'hA5);
      cpu_op(1'b0, 13'h0000, 8'h00);
      wait_read("wr_then_rd", 8'hA5);

      foreach (pool[i]) cpu_op(1'b1, pool[i], 8'($urandom));
      idle(12);

      // Burst into the attribute area, then read back in order.
      for (int i = 0; i < 6; i++) cpu_op(1'b1, ATTR_BASE + 13'(i), 8'h10 + 8'(i));
      idle(12);
      for (int i = 0; i < 4; i++) begin
         cpu_op(1'b0, ATTR_BASE + 13'(i), 8'h00);
         wait_read("attr_readback", 8'h10 + 8'(i));
      end
      chk("attr_region", 32'(is_attr_addr(ATTR_BASE)), 32'(1));

      // Display keeps its slots under continuous CPU writes.
      cpu_op(1'b1, 13'h1AFF, 8'h47);
      idle(12);
      fork
         begin
            for (int i = 0; i < 40; i++) rand_write_not(13'h1AFF);
         end
         begin
            for (int i = 0; i < 8; i++) begin
               video_addr = 13'h0000;
               idle(4);
               video_addr = 13'h1AFF;
               for (int k = 0; k < 3; k++) begin
                  @(posedge clk);
                  @(negedge clk);
                  if (video_data == 8'h47) break;
               end
               chk("video_latency", 32'(video_data), 32'h47);
               @(posedge clk);
               #1;
            end
         end
      join
      idle(12);

      // Border port.
      io_data = 3'b101;
      io_we   = 1'b1;
      idle(1);
      io_we   = 1'b0;
      @(negedge clk);
      chk("border_load", 32'(border), 32'b101);
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) rand_write_not(13'h1FFF + 13'(SCREEN_BYTES) - 13'(SCREEN_BYTES));
      @(negedge clk);
      chk("border_hold", 32'(border), 32'b101);
      @(posedge clk);
      #1;

      // Randomized mixed traffic.
      for (int i = 0; i < 150; i++) begin
         video_addr = pool[$urandom_range(0, 11)];
         if ($urandom_range(0, 4) == 0) begin
            io_data = 3'($urandom);
            io_we   = 1'b1;
            idle(1);
            io_we   = 1'b0;
         end
         cpu_op(1'($urandom), pool[$urandom_range(0, 11)], 8'($urandom));
         idle($urandom_range(0, 2));
      end
      idle(16);

      // Reset with three writes queued and a read pending.
      for (int i = 0; i < 6; i++) begin
         old_v[i] = refmem[int'(rt[i])];
         new_v[i] = ~old_v[i];
      end
      if (m_cyc % 2 != 0) idle(1);
      for (int i = 0; i < 6; i++) cpu_op(1'b1, rt[i], new_v[i]);
      cpu_op(1'b0, 13'h1800, 8'h00);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(cpu_ready), 32'(1));
      @(posedge clk);
      #1;
      idle(8);
      cpu_op(1'b0, rt[0], 8'h00);
      wait_read("rst_drained_write", new_v[0]);
      for (int i = 3; i < 6; i++) begin
         cpu_op(1'b0, rt[i], 8'h00);
         wait_read("rst_discarded_write", old_v[i]);
      end

      idle(16);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
